// File: rtl/srv_mem_pkg.sv
// Shared types and constants for the line-fill memory arbiter.
// The state encoding is kept here so the arbiter and any tooling agree on it.
package srv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } arb_state_t;

  localparam int LINE_W     = 128;
  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

endpackage

// File: rtl/srv_mem_arbiter_rr.sv
// Combinational requester picker: round-robin after the last winner, or fixed
// lowest-index priority. The last-winner pointer register lives in the parent.
module srv_rr_arbiter
  import srv_mem_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int PRIO_MODE = PRIO_RR,
  localparam int IW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] gnt
);

  logic [NREQ-1:0] above_last;
  logic [NREQ-1:0] masked;
  logic [NREQ-1:0] pick;

  // Fixed priority simply never masks, so the lowest requester always wins.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
    assign above_last[gi] = (PRIO_MODE != PRIO_FIXED) && (IW'(gi) > last);
  end

  assign masked = req & above_last;
  assign pick   = (|masked) ? masked : req;
  assign gnt    = pick & (~pick + NREQ'(1));

endmodule

// File: rtl/srv_mem_arbiter.sv
// Shares one line-fill memory port among NREQ requesters with a single
// outstanding transaction and a one-cycle response pulse to the winner.
module srv_mem_arbiter
  import srv_mem_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int DATA_W      = LINE_W,
  parameter int PRIO_MODE   = PRIO_RR,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_i,
  input  logic [NREQ*32-1:0]     addr_i,
  input  logic [NREQ-1:0]        we_i,
  input  logic [NREQ*DATA_W-1:0] wdata_i,
  output logic [NREQ-1:0]        rsp_o,
  output logic [DATA_W-1:0]      rdata_o,
  output logic                   err_o,
  output logic                   busy_o,
  output logic                   mem_req_o,
  output logic [31:0]            mem_addr_o,
  output logic                   mem_we_o,
  output logic [DATA_W-1:0]      mem_wdata_o,
  input  logic                   mem_gnt_i,
  input  logic                   mem_rsp_i,
  input  logic [DATA_W-1:0]      mem_rdata_i
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0] TMO_LAST = (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '0;

  arb_state_t        state_reg, state_next;
  logic [IW-1:0]     win_reg, last_reg, gnt_idx;
  logic [NREQ-1:0]   gnt;
  logic [31:0]       addr_reg;
  logic              we_reg;
  logic [DATA_W-1:0] wdata_reg, rdata_reg;
  logic              err_reg;
  logic [CW-1:0]     tmo_reg;
  logic              tmo_hit;

  srv_rr_arbiter #(
    .NREQ      (NREQ),
    .PRIO_MODE (PRIO_MODE)
  ) u_arb (
    .req  (req_i),
    .last (last_reg),
    .gnt  (gnt)
  );

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) gnt_idx = IW'(i);
    end
  end

  // tmo_reg counts completed WAIT cycles; the last one without a response expires.
  assign tmo_hit = (TIMEOUT_CYC > 0) && (tmo_reg == TMO_LAST);

  always_comb begin
    state_next = state_reg;
    rsp_o      = '0;
    err_o      = 1'b0;
    mem_req_o  = 1'b0;
    busy_o     = (state_reg != IDLE);
    case (state_reg)
      IDLE: if (|req_i) state_next = REQ;
      REQ: begin
        mem_req_o = 1'b1;
        if (mem_gnt_i) state_next = WAIT;
      end
      WAIT: if (mem_rsp_i || tmo_hit) state_next = RESP;
      RESP: begin
        rsp_o[win_reg] = 1'b1;
        err_o          = err_reg;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      win_reg   <= '0;
      last_reg  <= IW'(NREQ - 1);
      addr_reg  <= '0;
      we_reg    <= 1'b0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
      tmo_reg   <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: if (|req_i) begin
          win_reg   <= gnt_idx;
          addr_reg  <= addr_i[32*gnt_idx +: 32];
          we_reg    <= we_i[gnt_idx];
          wdata_reg <= wdata_i[DATA_W*gnt_idx +: DATA_W];
          err_reg   <= 1'b0;
        end
        // Holding the counter clear throughout REQ makes WAIT always start at zero.
        REQ: tmo_reg <= '0;
        WAIT: begin
          if (mem_rsp_i) begin
            rdata_reg <= mem_rdata_i;
          end else if (tmo_hit) begin
            rdata_reg <= '0;
            err_reg   <= 1'b1;
          end else begin
            tmo_reg <= tmo_reg + 1'b1;
          end
        end
        RESP: last_reg <= win_reg;
        default: ;
      endcase
    end
  end

  assign rdata_o     = rdata_reg;
  assign mem_addr_o  = addr_reg;
  assign mem_we_o    = we_reg;
  assign mem_wdata_o = wdata_reg;

endmodule

// File: tb/tb_srv_mem_arbiter.sv
// Bench for srv_mem_arbiter: a 3-requester round-robin instance with timeout
// and a 2-requester fixed-priority instance, each with its own memory model.
module tb_srv_mem_arbiter;

  logic clk;
  logic rst_n;

  // Instance A: NREQ=3, round-robin, TIMEOUT_CYC=8
  logic [2:0]   a_req, a_we, a_rsp;
  logic [95:0]  a_addr;
  logic [383:0] a_wdata;
  logic [127:0] a_rdata, a_mwdata, a_mrdata, a_line;
  logic         a_err, a_busy, a_mreq, a_mwe, a_gnt, a_mrsp, a_force, a_mrsp_in;
  logic [31:0]  a_maddr;

  // Instance B: NREQ=2, fixed priority, no timeout
  logic [1:0]   b_req, b_we, b_rsp;
  logic [63:0]  b_addr;
  logic [255:0] b_wdata;
  logic [127:0] b_rdata, b_mwdata, b_mrdata, b_line;
  logic         b_err, b_busy, b_mreq, b_mwe, b_gnt, b_mrsp, b_pend;
  logic [31:0]  b_maddr;

  int  total, bad;
  int  gnt_delay, rsp_delay, mphase, mcnt;
  bit  silent;
  int  last_win, cur_win;
  bit  prev_mreq;
  int  served [3];

  typedef struct {
    logic [2:0] req;
    logic       we;
    int         gd;
    int         rd;
    logic [2:0] exp_rsp;
    int         exp_lat;
  } vec_t;
  vec_t vt [8];

  srv_mem_arbiter #(.NREQ(3), .DATA_W(128), .PRIO_MODE(0), .TIMEOUT_CYC(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_i(a_req), .addr_i(a_addr), .we_i(a_we),
    .wdata_i(a_wdata), .rsp_o(a_rsp), .rdata_o(a_rdata), .err_o(a_err),
    .busy_o(a_busy), .mem_req_o(a_mreq), .mem_addr_o(a_maddr), .mem_we_o(a_mwe),
    .mem_wdata_o(a_mwdata), .mem_gnt_i(a_gnt), .mem_rsp_i(a_mrsp_in),
    .mem_rdata_i(a_mrdata)
  );

  srv_mem_arbiter #(.NREQ(2), .DATA_W(128), .PRIO_MODE(1), .TIMEOUT_CYC(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_i(b_req), .addr_i(b_addr), .we_i(b_we),
    .wdata_i(b_wdata), .rsp_o(b_rsp), .rdata_o(b_rdata), .err_o(b_err),
    .busy_o(b_busy), .mem_req_o(b_mreq), .mem_addr_o(b_maddr), .mem_we_o(b_mwe),
    .mem_wdata_o(b_mwdata), .mem_gnt_i(b_gnt), .mem_rsp_i(b_mrsp),
    .mem_rdata_i(b_mrdata)
  );

  assign a_mrsp_in = a_mrsp | a_force;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Winner = first requesting index strictly after the last winner, modulo 3.
  function automatic int rr_pick(input logic [2:0] r, input int last);
    int res;
    bit found;
    res = 0;
    found = 0;
    for (int k = 1; k <= 3; k++) begin
      if (!found && r[(last + k) % 3]) begin
        res = (last + k) % 3;
        found = 1;
      end
    end
    return res;
  endfunction

  // Memory model A: grant after gnt_delay REQ cycles, respond rsp_delay cycles later.
  always @(negedge clk) begin
    a_gnt = 1'b0;
    a_mrsp = 1'b0;
    a_mrdata = {$urandom, $urandom, $urandom, $urandom};
    if (!rst_n) begin
      mphase = 0;
      mcnt = 0;
    end else if (a_mreq) begin
      if (mphase != 1) begin
        mphase = 1;
        mcnt = 0;
      end
      if (mcnt >= gnt_delay) begin
        a_gnt = 1'b1;
        mphase = 2;
        mcnt = 0;
      end else begin
        mcnt++;
      end
    end else if (mphase == 2) begin
      if (!silent && mcnt >= rsp_delay) begin
        a_mrsp = 1'b1;
        a_line = a_mrdata;
        mphase = 0;
      end else begin
        mcnt++;
      end
    end
  end

  // Memory model B: zero-wait grant and response.
  always @(negedge clk) begin
    b_mrsp = 1'b0;
    b_mrdata = {$urandom, $urandom, $urandom, $urandom};
    if (!rst_n) begin
      b_pend = 1'b0;
    end else if (b_pend) begin
      b_mrsp = 1'b1;
      b_line = b_mrdata;
      b_pend = 1'b0;
    end
    b_gnt = b_mreq && rst_n;
    if (b_gnt) b_pend = 1'b1;
  end

  // Scoreboard for A: predicts winner on each new memory request, checks response.
  always @(posedge clk) begin
    #2;
    if (!rst_n) begin
      last_win = 2;
      prev_mreq = 1'b0;
    end else begin
      if (a_mreq && !prev_mreq) begin
        cur_win = rr_pick(a_req, last_win);
        chk("mon_any_req", {127'd0, |a_req}, 128'd1);
        chk("mon_addr", a_maddr, a_addr[32*cur_win +: 32]);
        chk("mon_we", a_mwe, a_we[cur_win]);
        chk("mon_wdata", a_mwdata, a_wdata[128*cur_win +: 128]);
      end
      if (a_rsp != 3'b000) begin
        chk("mon_rsp", a_rsp, 128'(1 << cur_win));
        chk("mon_rdata", a_rdata, silent ? 128'd0 : a_line);
        chk("mon_err", a_err, silent);
        $display("txn A win=%0d addr=%h we=%b rsp=%b err=%b rdata=%h",
                 cur_win, a_maddr, a_mwe, a_rsp, a_err, a_rdata);
        last_win = cur_win;
        served[cur_win]++;
      end
      prev_mreq = a_mreq;
    end
  end

  initial begin
    int  w, np, prev_c, nb, ntx;
    bit  got;
    logic [31:0] exp_addr;

    total = 0; bad = 0;
    rst_n = 1'b0;
    a_req = '0; a_we = '0; a_addr = '0; a_wdata = '0; a_force = 1'b0;
    b_req = '0; b_we = '0; b_addr = '0; b_wdata = '0;
    gnt_delay = 0; rsp_delay = 0; silent = 0;
    for (int i = 0; i < 3; i++) served[i] = 0;

    vt[0] = '{3'b001, 1'b0, 0, 0, 3'b001, 3};
    vt[1] = '{3'b011, 1'b0, 0, 0, 3'b010, 3};
    vt[2] = '{3'b011, 1'b0, 1, 1, 3'b001, 5};
    vt[3] = '{3'b101, 1'b0, 5, 0, 3'b100, 8};
    vt[4] = '{3'b111, 1'b1, 2, 3, 3'b001, 8};
    vt[5] = '{3'b110, 1'b0, 0, 0, 3'b010, 3};
    vt[6] = '{3'b100, 1'b0, 0, 4, 3'b100, 7};
    vt[7] = '{3'b010, 1'b1, 0, 2, 3'b010, 5};

    repeat (3) @(negedge clk);
    chk("rst_rsp", a_rsp, 0);
    chk("rst_err", a_err, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_mreq", a_mreq, 0);
    chk("rst_mwe", a_mwe, 0);
    chk("rst_maddr", a_maddr, 0);
    chk("rst_mwdata", a_mwdata, 0);
    chk("rst_rdata", a_rdata, 0);
    chk("rst_b_busy", b_busy, 0);
    chk("rst_b_mreq", b_mreq, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed single transactions with known round-robin history.
    for (int k = 0; k < 8; k++) begin
      gnt_delay = vt[k].gd;
      rsp_delay = vt[k].rd;
      for (int i = 0; i < 3; i++) begin
        a_addr[32*i +: 32] = 32'h100 * (i + 1) + k * 16;
        a_wdata[128*i +: 128] = {$urandom, $urandom, $urandom, $urandom};
      end
      a_we = {3{vt[k].we}};
      a_req = vt[k].req;
      w = 0;
      for (int i = 0; i < 3; i++) if (vt[k].exp_rsp[i]) w = i;
      exp_addr = 32'h100 * (w + 1) + k * 16;
      got = 0;
      for (int c = 1; c <= 40 && !got; c++) begin
        @(negedge clk);
        if (c == 1) chk("tbl_req_latency", a_mreq, 1);
        if (a_mreq) chk("tbl_addr_stable", a_maddr, exp_addr);
        if (a_rsp != 3'b000) begin
          chk("tbl_rsp", a_rsp, vt[k].exp_rsp);
          chk("tbl_latency", c, vt[k].exp_lat);
          chk("tbl_err", a_err, 0);
          got = 1;
        end
      end
      chk("tbl_got_rsp", got, 1);
      a_req = '0;
      repeat (2) @(negedge clk);
    end

    // Continuous contention between requesters 0 and 1.
    gnt_delay = 0; rsp_delay = 0;
    a_req = 3'b011;
    np = 0; prev_c = 0;
    for (int c = 0; c < 80 && np < 8; c++) begin
      @(negedge clk);
      if (a_rsp != 3'b000) begin
        chk("rr_alternate", a_rsp, (np % 2 == 0) ? 3'b001 : 3'b010);
        if (np > 0) chk("rr_period", c - prev_c, 4);
        prev_c = c;
        np++;
      end
    end
    chk("rr_pulse_count", np, 8);
    a_req = '0;
    repeat (3) @(negedge clk);

    // Memory never responds: error response exactly 8 WAIT cycles later.
    silent = 1;
    a_addr[31:0] = 32'h300; a_we = '0; a_req = 3'b001;
    got = 0;
    for (int c = 1; c <= 30 && !got; c++) begin
      @(negedge clk);
      if (a_rsp != 3'b000) begin
        chk("tmo_latency", c, 10);
        chk("tmo_rsp", a_rsp, 3'b001);
        chk("tmo_err", a_err, 1);
        chk("tmo_rdata", a_rdata, 0);
        got = 1;
      end
    end
    chk("tmo_got_rsp", got, 1);
    a_req = '0;
    silent = 0;
    repeat (2) @(negedge clk);
    a_addr[63:32] = 32'h400; a_req = 3'b010;
    got = 0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      if (a_rsp != 3'b000) begin
        chk("post_tmo_latency", c, 3);
        chk("post_tmo_err", a_err, 0);
        got = 1;
      end
    end
    chk("post_tmo_got_rsp", got, 1);
    a_req = '0;
    repeat (2) @(negedge clk);

    // Reset while in WAIT, then a stray memory response.
    silent = 1;
    a_addr[31:0] = 32'h500; a_req = 3'b001;
    repeat (2) @(negedge clk);
    chk("pre_rst_busy", a_busy, 1);
    #1 rst_n = 1'b0;
    a_req = '0;
    #1;
    chk("mid_rst_busy", a_busy, 0);
    chk("mid_rst_mreq", a_mreq, 0);
    chk("mid_rst_rsp", a_rsp, 0);
    @(negedge clk);
    rst_n = 1'b1;
    silent = 0;
    @(negedge clk);
    a_force = 1'b1;
    @(negedge clk);
    a_force = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stray_rsp", a_rsp, 0);
      chk("stray_busy", a_busy, 0);
    end
    a_addr[63:32] = 32'h600; a_req = 3'b010;
    got = 0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      if (a_rsp != 3'b000) begin
        chk("post_rst_rsp", a_rsp, 3'b010);
        chk("post_rst_latency", c, 3);
        got = 1;
      end
    end
    chk("post_rst_got_rsp", got, 1);
    a_req = '0;
    repeat (2) @(negedge clk);

    // Fixed priority: requester 0 keeps winning until it drops.
    b_addr = {32'h2000, 32'h1000};
    b_wdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    b_we = 2'b00;
    b_req = 2'b11;
    nb = 0;
    for (int c = 0; c < 60 && nb < 4; c++) begin
      @(negedge clk);
      if (b_rsp != 2'b00) begin
        chk("fp_rsp", b_rsp, (nb < 3) ? 2'b01 : 2'b10);
        chk("fp_addr", b_maddr, (nb < 3) ? 32'h1000 : 32'h2000);
        chk("fp_rdata", b_rdata, b_line);
        chk("fp_err", b_err, 0);
        $display("txn B rsp=%b addr=%h rdata=%h", b_rsp, b_maddr, b_rdata);
        if (nb == 2) b_req[0] = 1'b0;
        if (nb == 3) b_req[1] = 1'b0;
        nb++;
      end
    end
    chk("fp_count", nb, 4);

    // Randomized traffic on A, checked by the scoreboard.
    for (int i = 0; i < 3; i++) served[i] = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (!a_busy) begin
        gnt_delay = $urandom_range(0, 3);
        rsp_delay = $urandom_range(0, 4);
      end
      for (int i = 0; i < 3; i++) begin
        if (a_req[i] && a_rsp[i]) begin
          a_req[i] = 1'b0;
        end else if (!a_req[i] && $urandom_range(0, 2) == 0) begin
          a_addr[32*i +: 32] = $urandom;
          a_we[i] = 1'($urandom_range(0, 1));
          a_wdata[128*i +: 128] = {$urandom, $urandom, $urandom, $urandom};
          a_req[i] = 1'b1;
        end
      end
    end
    got = 0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) if (a_req[i] && a_rsp[i]) a_req[i] = 1'b0;
      if (a_req == 3'b000 && !a_busy) got = 1;
    end
    chk("rand_drain", got, 1);
    ntx = served[0] + served[1] + served[2];
    chk("rand_enough_txn", ntx > 40, 1);
    for (int i = 0; i < 3; i++) chk("rand_no_starve", served[i] > 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/srv_mem_arbiter.md
Name: srv_mem_arbiter

Overview:
- Shares one external line-fill memory port between NREQ requesters, e.g. the instruction cache refill port (requester 0) and a data-side port (requester 1).
- Arbitrates, latches the winning request, sequences a single outstanding memory transaction, and returns the 128-bit line to the winner with a one-cycle response pulse.
- Sits between the core's memory clients and the memory model/bus in the top level.

Parameters:
- NREQ, 2, number of requesters (2..8).
- DATA_W, 128, line width in bits.
- PRIO_MODE, 0, 0 = round-robin; 1 = fixed priority, lowest index wins.
- TIMEOUT_CYC, 0, maximum WAIT cycles before forced error response; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- req_i  in  NREQ  per-requester request level; held until that requester's rsp_o
- addr_i  in  NREQ*32  per-requester line address, slice i = [32*i +: 32]
- we_i  in  NREQ  per-requester write enable
- wdata_i  in  NREQ*DATA_W  per-requester write line
- rsp_o  out  NREQ  one-hot, one-cycle response pulse
- rdata_o  out  DATA_W  registered read line, valid while any rsp_o is high
- err_o  out  1  qualifies rsp_o: transaction timed out
- busy_o  out  1  FSM not in IDLE
- mem_req_o  out  1  memory request; held until mem_gnt_i
- mem_addr_o  out  32  latched address
- mem_we_o  out  1  latched write enable
- mem_wdata_o  out  DATA_W  latched write data
- mem_gnt_i  in  1  memory accepted the request (sampled while mem_req_o=1)
- mem_rsp_i  in  1  one-cycle response strobe
- mem_rdata_i  in  DATA_W  response data, valid with mem_rsp_i

Behaviour:
- Reset is asynchronous, active-low rst_n; clock is clk.
- Reset values:
  - state = IDLE.
  - rsp_o, err_o, busy_o, mem_req_o and mem_we_o = 0.
  - mem_addr_o, mem_wdata_o and rdata_o = 0.
  - Round-robin pointer set so requester 0 wins first.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - If |req_i: pick winner, latch addr/we/wdata and winner index, go to REQ.
  - Else stay in IDLE.
- REQ:
  - mem_req_o = 1 with the latched fields.
  - On mem_gnt_i go to WAIT, else hold in REQ.
  - Latched fields are stable for the whole of REQ and WAIT.
- WAIT:
  - On mem_rsp_i: register mem_rdata_i into rdata_o (write transactions also register it), go to RESP.
  - If TIMEOUT_CYC>0 and the WAIT cycle count reaches TIMEOUT_CYC with no mem_rsp_i: rdata_o = 0, set err flag, go to RESP.
- RESP:
  - rsp_o[winner] = 1 for exactly one cycle; err_o = timeout flag.
  - Go to IDLE and update the round-robin pointer to the winner.
  - No arbitration in RESP, so the winner's still-high req_i is never re-granted.
- Latency:
  - Request to mem_req_o: 1 cycle (req sampled in IDLE at cycle 0, mem_req_o high at cycle 1).
  - Zero-wait memory (gnt at cycle 1, rsp at cycle 2): rsp_o at cycle 3.
  - Earliest back-to-back re-arbitration: cycle 4.
- Round-robin: the winner is the first requesting index strictly after the last winner, wrapping modulo NREQ.
- Fixed priority: lowest requesting index wins.
- mem_rsp_i outside WAIT (including the same cycle as gnt in REQ) is ignored.
- A requester dropping req_i mid-transaction does not abort it; the response is still delivered.
- Requesters must not change addr/we/wdata while req_i is high.
- Timeout counter is cleared on entry to WAIT; width is clog2(TIMEOUT_CYC+1).
- rdata_o holds its value between responses.
- rst_n asserted mid-transaction returns to IDLE immediately and drops mem_req_o. The memory model is reset together with the arbiter.

Decomposition:
- Package srv_mem_pkg:
  - arb_state_t enum {IDLE, REQ, WAIT, RESP}.
  - Constants LINE_W=128 and PRIO_RR=0 / PRIO_FIXED=1.
- Sub-module srv_rr_arbiter (combinational):
  - Inputs: req vector, last-grant pointer, PRIO_MODE.
  - Output: one-hot grant.
  - Instantiated once; the pointer register stays in srv_mem_arbiter.

Test Plan:
1. Single read: req_i=01, addr0=0x0000_0100; memory gnt at cycle 1, rsp at cycle 2 with data 0x...DEADBEEF -> mem_addr_o=0x100, rsp_o=01 at cycle 3, rdata_o=0x...DEADBEEF, err_o=0.
2. Round-robin contention: req_i=11 held continuously, zero-wait memory -> grants alternate 0,1,0,1; rsp_o pulses 01,10,01,10 every 4 cycles; neither requester starves.
3. Fixed priority: PRIO_MODE=1, req_i=11 held -> requester 0 served each time, requester 1 served only after req0 drops.
4. Grant back-pressure: mem_gnt_i low for 5 cycles -> mem_req_o and mem_addr_o stable for 6 cycles; rsp_o arrives 1 cycle after mem_rsp_i.
5. Timeout: TIMEOUT_CYC=8, memory never responds -> rsp_o pulse with err_o=1 and rdata_o=0 exactly 8 cycles after WAIT entry; next request served normally.
6. Reset mid-WAIT: rst_n low for 1 cycle in WAIT -> mem_req_o, rsp_o and busy_o = 0 immediately; a stray mem_rsp_i after reset causes no rsp_o; a new req completes normally.
